// File: rtl/r200_fetchq_pkg.sv
// Shared types and constants for the r200 instruction-fetch front end.
package r200_fetchq_pkg;

  localparam int unsigned R200_XLEN     = 32;
  localparam logic [31:0] R200_NOP      = 32'h0000_0013;
  localparam logic [31:0] R200_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FQ_RUN,
    FQ_FLUSH
  } fq_state_e;

  typedef struct packed {
    logic [R200_XLEN-1:0] instrn;
    logic [R200_XLEN-1:0] pc;
  } fq_entry_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/r200_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only alongside a pop.
module r200_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          wr_en, rd_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i && !flush_i) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (rd_en) rd_q <= rd_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/r200_fetchq.sv
// Decoupled fetch front end: owns the fetch PC, issues in-order imem requests,
// buffers responses in a prefetch FIFO and drops stale responses after a redirect.
module r200_fetchq
  import r200_fetchq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = R200_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instrn,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcp4
);

  localparam int unsigned CW        = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

  fq_state_e     state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  fq_entry_t     push_entry, head;
  logic [CW:0]   credit_used;
  logic          req_fire, dropping;

  // Slots already promised: kept in-flight responses plus buffered entries.
  assign credit_used = {1'b0, out_cnt_q} - {1'b0, drop_cnt_q} + {1'b0, fifo_cnt};

  assign imem_req_valid = !rst && !redirect_valid && (out_cnt_q < MAX_OUT_C)
                          && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign dropping   = (state_q == FQ_FLUSH);
  assign fifo_push  = imem_rsp_valid && !dropping && !redirect_valid;
  assign push_entry = '{instrn: imem_rsp_data, pc: rsp_pc_q};

  assign out_valid  = !fifo_empty && !redirect_valid;
  assign fifo_pop   = out_valid && out_ready;
  assign out_instrn = fifo_empty ? R200_NOP : head.instrn;
  assign out_pc     = head.pc;
  assign out_pcp4   = pc_next(head.pc);

  r200_fifo #(
    .W     ($bits(fq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .din_i   (push_entry),
    .pop_i   (fifo_pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (req_fire && !imem_rsp_valid) out_cnt_d = out_cnt_q + CW'(1);
    if (!req_fire && imem_rsp_valid) out_cnt_d = out_cnt_q - CW'(1);

    // A redirect makes every request still outstanding after this cycle stale.
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      drop_cnt_d = out_cnt_d;
    end else if (imem_rsp_valid && dropping) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = word_align(redirect_pc);
    else if (req_fire)   fetch_pc_d = pc_next(fetch_pc_q);

    rsp_pc_d = rsp_pc_q;
    if (redirect_valid)  rsp_pc_d = word_align(redirect_pc);
    else if (fifo_push)  rsp_pc_d = pc_next(rsp_pc_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FQ_RUN;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      case (state_q)
        FQ_RUN:   if (redirect_valid && out_cnt_d != '0) state_q <= FQ_FLUSH;
        FQ_FLUSH: begin
          if (redirect_valid)          state_q <= (out_cnt_d != '0) ? FQ_FLUSH : FQ_RUN;
          else if (drop_cnt_d == '0)   state_q <= FQ_RUN;
        end
        default:  state_q <= FQ_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && fifo_full && !fifo_pop));
    end
  end

endmodule

// File: tb/tb_r200_fetchq.sv
// Scoreboard bench for r200_fetchq: a transaction-level memory/fetch model feeds
// expected outputs into a queue that an independent monitor checks.
module tb_r200_fetchq;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instrn, out_pc, out_pcp4;

  always #5 clk = ~clk;

  r200_fetchq #(
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instrn     (out_instrn),
    .out_pc         (out_pc),
    .out_pcp4       (out_pcp4)
  );

  int unsigned total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    int unsigned cyc;
  } exp_t;

  req_t        pend[$];
  exp_t        sbq[$];
  int unsigned cycle = 0;
  int unsigned lat = 1, rdy_pct = 100, ordy_pct = 100;
  logic [31:0] mfetch = RESET_PC;
  int unsigned pops = 0;

  // Memory and handshake driver: in-order responses after 'lat' cycles.
  always @(posedge clk) begin
    cycle++;
    #1;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    out_ready      = ($urandom_range(99) < ordy_pct);
    if (!rst && pend.size() > 0 && pend[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // Reference model: tracks fetch address, outstanding/stale requests, expected outputs.
  always @(negedge clk) begin : model
    int unsigned nst;
    int unsigned kept;
    req_t r;
    if (rst) begin
      pend.delete();
      sbq.delete();
      mfetch = RESET_PC;
    end else begin
      nst = 0;
      foreach (pend[i]) if (pend[i].stale) nst++;
      check("outstanding", 32'(dut.out_cnt_q), pend.size());
      check("drop_cnt", 32'(dut.drop_cnt_q), nst);
      check("inv_out_le_max", 32'(dut.out_cnt_q <= MAX_OUT), 32'd1);
      check("inv_cnt_le_depth", 32'(dut.fifo_cnt <= DEPTH), 32'd1);
      check("inv_drop_le_out", 32'(dut.drop_cnt_q <= dut.out_cnt_q), 32'd1);
      check("inv_no_push_full", 32'(!(dut.fifo_push && dut.fifo_full && !dut.fifo_pop)), 32'd1);
      if (redirect_valid) begin
        check("redir_no_req", 32'(imem_req_valid), 32'd0);
        check("redir_no_out", 32'(out_valid), 32'd0);
      end
      if (imem_rsp_valid && pend.size() > 0) begin
        r = pend.pop_front();
        if (!r.stale && !redirect_valid) sbq.push_back('{r.addr, mem_word(r.addr), cycle});
      end
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, mfetch);
        pend.push_back('{mfetch, cycle + lat, 1'b0});
        mfetch = mfetch + 32'd4;
      end
      if (redirect_valid) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        sbq.delete();
        mfetch = {redirect_pc[31:2], 2'b00};
      end
      kept = sbq.size();
      foreach (pend[i]) if (!pend[i].stale) kept++;
      check("credit", 32'(kept <= DEPTH), 32'd1);
    end
  end

  // Monitor: compares every output handshake against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        pops++;
        if (sbq.size() == 0 || sbq[0].cyc >= cycle) begin
          check("out_unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_pcp4", out_pcp4, e.pc + 32'd4);
          check("out_instrn", out_instrn, e.ins);
        end
      end else if (!redirect_valid && sbq.size() > 0 && sbq[0].cyc < cycle) begin
        check("out_valid_pending", 32'(out_valid), 32'd1);
      end
    end
  end

  task automatic wait_first_out(input string name, input logic [31:0] pc_exp,
                                input logic [31:0] pcp4_exp);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        check({name, "_pc"}, out_pc, pc_exp);
        check({name, "_pcp4"}, out_pcp4, pcp4_exp);
        found = 1;
        break;
      end
    end
    check({name, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_outstanding2(input string name);
    bit found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dut.out_cnt_q == 2) begin
        found = 1;
        break;
      end
    end
    check({name, "_out2_seen"}, 32'(found), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int unsigned pre_out;
    logic        pre_rsp;
    bit          found;

    // Reset and streaming
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_outstanding", 32'(dut.out_cnt_q), 32'd0);
    check("rst_fifo_cnt", 32'(dut.fifo_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RESET_PC);
    wait_first_out("stream_first", 32'h0, 32'h4);
    repeat (30) @(posedge clk);

    // Backpressure from a fresh reset
    ordy_pct = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("bp_fifo_full", 32'(dut.fifo_cnt), DEPTH);
    check("bp_req_stalled", 32'(imem_req_valid), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    ordy_pct = 100;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        check("bp_resume_addr", imem_req_addr, 32'h10);
        found = 1;
        break;
      end
    end
    check("bp_resume_seen", 32'(found), 32'd1);
    repeat (20) @(posedge clk);

    // Redirect with two outstanding, 3-cycle latency
    lat = 3;
    wait_outstanding2("redir");
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    pre_out = dut.out_cnt_q;
    pre_rsp = imem_rsp_valid;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_drop", 32'(dut.drop_cnt_q), pre_out - 32'(pre_rsp));
    check("redir_fifo_empty", 32'(dut.fifo_cnt), 32'd0);
    wait_first_out("redir_first", 32'h100, 32'h104);
    repeat (10) @(posedge clk);

    // Redirect coincident with a response and a pop
    lat = 1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (imem_rsp_valid && out_valid && out_ready) begin
        pre_out        = dut.out_cnt_q;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        found          = 1;
        break;
      end
    end
    check("coinc_seen", 32'(found), 32'd1);
    if (found) begin
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      check("coinc_drop", 32'(dut.drop_cnt_q), pre_out - 1);
      check("coinc_fifo_empty", 32'(dut.fifo_cnt), 32'd0);
      wait_first_out("coinc_first", 32'h200, 32'h204);
    end
    repeat (10) @(posedge clk);

    // Wrap and misaligned redirect
    lat = 2;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_first_out("wrap_first", 32'hFFFF_FFFC, 32'h0000_0000);
    repeat (10) @(posedge clk);

    // Randomized traffic with random redirects
    rdy_pct  = 70;
    ordy_pct = 60;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(15) == 0) lat = $urandom_range(3, 1);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = $urandom;
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    repeat (10) @(posedge clk);

    // Reset mid-operation
    rdy_pct  = 100;
    ordy_pct = 100;
    lat      = 3;
    wait_outstanding2("midrst");
    ordy_pct = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_outstanding", 32'(dut.out_cnt_q), 32'd0);
    check("midrst_req_valid", 32'(imem_req_valid), 32'd1);
    check("midrst_req_addr", imem_req_addr, RESET_PC);
    ordy_pct = 100;
    lat      = 1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("pops_seen", 32'(pops >= 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
